// File: rtl/hdr_collector.sv
// ---------------------------------------------------------------------------
// hdr_collector
//
// Upstream feeder for the header parser. Collects a byte-serial packet,
// captures the first HDR_LEN bytes into a zero-padded header window, fires a
// one-cycle start at the parser (held off while the parser tables are being
// modified), waits for the parser to finish and then presents the parsed
// offsets together with the packet length on a valid/ready output.
//
// Optional feature macro: HDR_COLLECTOR_TIMEOUT_EN
//   Defined     - a wait counter bounds WAIT_DONE to TIMEOUT cycles; on expiry
//                 the result is emitted with out_err_o=1 and every offset word
//                 set to `NO_HEADER.
//   Not defined - WAIT_DONE waits indefinitely and out_err_o is tied low.
//
// Ports:
//   clk             in   clock, all logic on posedge
//   rst             in   asynchronous active-low reset
//   in_valid_i      in   input byte valid
//   in_ready_o      out  input byte accepted when high with in_valid_i
//   in_data_i       in   packet byte
//   in_sop_i        in   first byte of packet
//   in_eop_i        in   last byte of packet
//   mod_busy_i      in   parser table modification active, blocks start
//   start_o         out  one-cycle parser start
//   pkt_hdr_o       out  HDR_LEN x 8 header window (byte i at [i*8 +: 8])
//   parser_ready_i  in   parser done (level)
//   parsed_hdrs_i   in   NUM_HDRS x 32 parser offsets
//   out_valid_o     out  result valid
//   out_ready_i     in   downstream accept
//   out_hdrs_o      out  NUM_HDRS x 32 latched offsets
//   out_pkt_len_o   out  total packet bytes, saturating at 65535
//   out_err_o       out  parser timeout flag
// ---------------------------------------------------------------------------

`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif

`ifndef NUM_HEADERS
`define NUM_HEADERS 2
`endif

`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif

module hdr_collector #(
  parameter int HDR_LEN  = `HDR_MAX_LEN,
  parameter int NUM_HDRS = `NUM_HEADERS,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [7:0]               in_data_i,
  input  logic                     in_sop_i,
  input  logic                     in_eop_i,
  input  logic                     mod_busy_i,
  output logic                     start_o,
  output logic [HDR_LEN*8-1:0]     pkt_hdr_o,
  input  logic                     parser_ready_i,
  input  logic [NUM_HDRS*32-1:0]   parsed_hdrs_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM_HDRS*32-1:0]   out_hdrs_o,
  output logic [15:0]              out_pkt_len_o,
  output logic                     out_err_o
);

  localparam int CW = $clog2(HDR_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DISPATCH,
    START,
    WAIT_DONE,
    OUTPUT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic            accept;
  logic            timed_out;

  if (HDR_LEN < 1 || NUM_HDRS < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("hdr_collector: HDR_LEN, NUM_HDRS and TIMEOUT must all be >= 1");
  end

  // Gating with rst keeps the input closed for the whole reset interval,
  // even though the state register already reads IDLE.
  assign in_ready_o = rst & ((state == IDLE) | (state == COLLECT));
  assign accept     = in_valid_i & in_ready_o;

`ifdef HDR_COLLECTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Held at zero outside WAIT_DONE, so it reads 0 on the first WAIT_DONE
  // cycle; expiry lands after exactly TIMEOUT cycles without parser_ready_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != WAIT_DONE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == WAIT_DONE) && !parser_ready_i &&
                     (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_err_o <= 1'b0;
    end else if (timed_out) begin
      out_err_o <= 1'b1;
    end else if (state == OUTPUT && out_ready_i) begin
      out_err_o <= 1'b0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign out_err_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe outputs.
  always_comb begin
    state_nxt   = state;
    start_o     = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept && in_sop_i) begin
          state_nxt = in_eop_i ? DISPATCH : COLLECT;
        end
      end
      COLLECT: begin
        if (accept && in_eop_i) begin
          state_nxt = DISPATCH;
        end
      end
      DISPATCH: begin
        if (!mod_busy_i) begin
          state_nxt = START;
        end
      end
      START: begin
        start_o   = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (parser_ready_i || timed_out) begin
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Header window, byte count and packet length. Writes only happen on an
  // accepted byte, which confines window updates to IDLE and COLLECT. A sop
  // in either state restarts the packet from scratch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_hdr_o     <= '0;
      count         <= '0;
      out_pkt_len_o <= '0;
    end else if (accept && in_sop_i) begin
      pkt_hdr_o     <= (HDR_LEN*8)'(in_data_i);
      count         <= CW'(1);
      out_pkt_len_o <= 16'd1;
    end else if (accept && state == COLLECT) begin
      if (count < CW'(HDR_LEN)) begin
        pkt_hdr_o[int'(count)*8 +: 8] <= in_data_i;
        count                         <= count + 1'b1;
      end
      if (out_pkt_len_o != 16'hFFFF) begin
        out_pkt_len_o <= out_pkt_len_o + 16'd1;
      end
    end
  end

  // Offset latch: parser result, or the no-header pattern on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_hdrs_o <= '0;
    end else if (state == WAIT_DONE && parser_ready_i) begin
      out_hdrs_o <= parsed_hdrs_i;
    end else if (timed_out) begin
      out_hdrs_o <= {NUM_HDRS{`NO_HEADER}};
    end
  end

endmodule

// File: tb/tb_hdr_collector.sv
// ---------------------------------------------------------------------------
// tb_hdr_collector
//
// Directed bench for hdr_collector with a small parser model that drops its
// ready on the edge sampling start_o and raises it again after a fixed
// latency, presenting a bench-chosen offset pair.
// ---------------------------------------------------------------------------

`ifndef NO_HEADER
`define NO_HEADER 32'hFFFF_FFFF
`endif

module tb_hdr_collector;

  localparam int HDR_LEN  = 64;
  localparam int NUM_HDRS = 2;
  localparam int TIMEOUT  = 255;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  logic                    in_sop;
  logic                    in_eop;
  logic                    mod_busy;
  logic                    start;
  logic [HDR_LEN*8-1:0]    pkt_hdr;
  logic                    parser_ready;
  logic [NUM_HDRS*32-1:0]  parsed_hdrs;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_HDRS*32-1:0]  out_hdrs;
  logic [15:0]             out_pkt_len;
  logic                    out_err;

  int errors = 0;
  int checks = 0;

  logic [NUM_HDRS*32-1:0]  model_hdrs;
  int                      plat = 2;
  bit                      parser_en = 1'b1;
  int                      pcnt;
  bit                      pend;
  int                      start_count = 0;

  hdr_collector #(
    .HDR_LEN (HDR_LEN),
    .NUM_HDRS(NUM_HDRS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .in_sop_i      (in_sop),
    .in_eop_i      (in_eop),
    .mod_busy_i    (mod_busy),
    .start_o       (start),
    .pkt_hdr_o     (pkt_hdr),
    .parser_ready_i(parser_ready),
    .parsed_hdrs_i (parsed_hdrs),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_hdrs_o    (out_hdrs),
    .out_pkt_len_o (out_pkt_len),
    .out_err_o     (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parser model: ready drops when start is sampled, rises plat+1 edges later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      parser_ready <= 1'b0;
      parsed_hdrs  <= '0;
      pend         <= 1'b0;
      pcnt         <= 0;
    end else if (start) begin
      parser_ready <= 1'b0;
      pend         <= 1'b1;
      pcnt         <= plat;
    end else if (pend && parser_en) begin
      if (pcnt == 0) begin
        parser_ready <= 1'b1;
        parsed_hdrs  <= model_hdrs;
        pend         <= 1'b0;
      end else begin
        pcnt <= pcnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (start) start_count <= start_count + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int n, input int base, input bit sop_first, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      in_sop   = (i == 0) && sop_first;
      in_eop   = (i == n - 1) && eop_last;
      tick();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got rdy=%b start=%b valid=%b err=%b expected all 0",
               in_ready, start, out_valid, out_err);
    end
    checks++;
    if (pkt_hdr !== '0 || out_hdrs !== '0 || out_pkt_len !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got hdrs=%h len=%0d expected 0", out_hdrs, out_pkt_len);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_short_packet();
    logic [HDR_LEN*8-1:0] exp_hdr;
    int s0;
    bit ok;
    exp_hdr = '0;
    for (int i = 0; i < 14; i++) exp_hdr[i*8 +: 8] = 8'(i);
    model_hdrs = {32'd14, 32'd0};
    s0 = start_count;
    send_bytes(14, 0, 1'b1, 1'b1);
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_start_n1: got %b expected 0", start);
    end
    tick();
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_start_n2: got %b expected 1", start);
    end
    checks++;
    if (pkt_hdr !== exp_hdr) begin
      errors++;
      $display("[TB] FAIL short_window: got %h expected %h", pkt_hdr, exp_hdr);
    end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (parser_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_ready_cycle: got ready_seen=%b valid=%b expected 1 and 0", ok, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_valid_latency: got %b expected 1", out_valid);
    end
    checks++;
    if (out_hdrs !== {32'd14, 32'd0} || out_pkt_len !== 16'd14 || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_result: got hdrs=%h len=%0d err=%b expected hdrs=%h len=14 err=0",
               out_hdrs, out_pkt_len, out_err, {32'd14, 32'd0});
    end
    checks++;
    if (pkt_hdr !== exp_hdr) begin
      errors++;
      $display("[TB] FAIL short_window_stable: got %h expected %h", pkt_hdr, exp_hdr);
    end
    checks++;
    if (start_count - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL short_start_once: got %0d pulses expected 1", start_count - s0);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_release: got valid=%b rdy=%b expected 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_long_packet();
    logic [HDR_LEN*8-1:0] exp_hdr;
    bit ok;
    for (int i = 0; i < HDR_LEN; i++) exp_hdr[i*8 +: 8] = 8'(i);
    model_hdrs = {32'd20, 32'd0};
    send_bytes(100, 0, 1'b1, 1'b1);
    wait_valid(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL long_valid_timeout: got valid=%b expected 1", out_valid);
    end
    checks++;
    if (pkt_hdr !== exp_hdr) begin
      errors++;
      $display("[TB] FAIL long_window: got %h expected %h", pkt_hdr, exp_hdr);
    end
    checks++;
    if (out_pkt_len !== 16'd100 || out_hdrs !== {32'd20, 32'd0}) begin
      errors++;
      $display("[TB] FAIL long_result: got len=%0d hdrs=%h expected len=100 hdrs=%h",
               out_pkt_len, out_hdrs, {32'd20, 32'd0});
    end
    handshake();
  endtask

  task automatic test_mod_busy();
    int s0;
    bit ok;
    model_hdrs = {32'd9, 32'd1};
    s0 = start_count;
    mod_busy = 1'b1;
    send_bytes(14, 8'h20, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_hold_%0d: got start=%b expected 0", k, start);
      end
      tick();
    end
    mod_busy = 1'b0;
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_fall_cycle: got start=%b expected 0", start);
    end
    tick();
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_start_after: got start=%b expected 1", start);
    end
    wait_valid(30, ok);
    checks++;
    if (!ok || start_count - s0 !== 1 || out_hdrs !== {32'd9, 32'd1}) begin
      errors++;
      $display("[TB] FAIL busy_result: got valid=%b pulses=%0d hdrs=%h expected 1, 1, %h",
               ok, start_count - s0, out_hdrs, {32'd9, 32'd1});
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [HDR_LEN*8-1:0] exp_hdr;
    bit ok;
    model_hdrs = {32'd7, 32'd3};
    send_bytes(6, 8'h40, 1'b1, 1'b1);
    wait_valid(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL bp_valid_timeout: got valid=%b expected 1", out_valid);
    end
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_eop   = 1'b0;
    in_data  = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_hdrs !== {32'd7, 32'd3} || out_pkt_len !== 16'd6 ||
          in_ready !== 1'b0 || pkt_hdr[7:0] !== 8'h40) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b hdrs=%h len=%0d rdy=%b b0=%h expected 1 %h 6 0 40",
                 k, out_valid, out_hdrs, out_pkt_len, in_ready, pkt_hdr[7:0], {32'd7, 32'd3});
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_handshake_ready: got %b expected 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pkt_hdr[7:0] !== 8'h40) begin
      errors++;
      $display("[TB] FAIL bp_after_handshake: got valid=%b rdy=%b b0=%h expected 0 1 40",
               out_valid, in_ready, pkt_hdr[7:0]);
    end
    tick();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    checks++;
    if (pkt_hdr[7:0] !== 8'hAA || out_pkt_len !== 16'd1) begin
      errors++;
      $display("[TB] FAIL bp_next_first: got b0=%h len=%0d expected AA 1", pkt_hdr[7:0], out_pkt_len);
    end
    model_hdrs = {32'd2, 32'd0};
    send_bytes(2, 8'hAB, 1'b0, 1'b1);
    wait_valid(30, ok);
    exp_hdr = '0;
    exp_hdr[23:0] = 24'hACABAA;
    checks++;
    if (!ok || out_pkt_len !== 16'd3 || pkt_hdr !== exp_hdr || out_hdrs !== {32'd2, 32'd0}) begin
      errors++;
      $display("[TB] FAIL bp_next_result: got valid=%b len=%0d win=%h hdrs=%h expected 1 3 %h %h",
               ok, out_pkt_len, pkt_hdr[31:0], out_hdrs, exp_hdr[31:0], {32'd2, 32'd0});
    end
    handshake();
  endtask

  task automatic test_stray_restart();
    logic [HDR_LEN*8-1:0] exp_hdr;
    bit ok;
    exp_hdr = '0;
    exp_hdr[23:0] = 24'hACABAA;
    send_bytes(3, 8'h90, 1'b0, 1'b0);
    checks++;
    if (pkt_hdr !== exp_hdr || out_pkt_len !== 16'd3 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_discard: got win=%h len=%0d rdy=%b valid=%b expected %h 3 1 0",
               pkt_hdr[31:0], out_pkt_len, in_ready, out_valid, exp_hdr[31:0]);
    end
    model_hdrs = {32'd4, 32'd1};
    send_bytes(5, 8'h10, 1'b1, 1'b0);
    checks++;
    if (out_pkt_len !== 16'd5 || pkt_hdr[39:0] !== 40'h1413121110) begin
      errors++;
      $display("[TB] FAIL stray_first_part: got len=%0d win=%h expected 5 1413121110",
               out_pkt_len, pkt_hdr[39:0]);
    end
    send_bytes(4, 8'h50, 1'b1, 1'b1);
    exp_hdr = '0;
    exp_hdr[31:0] = 32'h53525150;
    wait_valid(30, ok);
    checks++;
    if (!ok || out_pkt_len !== 16'd4 || pkt_hdr !== exp_hdr || out_hdrs !== {32'd4, 32'd1}) begin
      errors++;
      $display("[TB] FAIL stray_restart: got valid=%b len=%0d win=%h hdrs=%h expected 1 4 %h %h",
               ok, out_pkt_len, pkt_hdr[47:0], out_hdrs, exp_hdr[47:0], {32'd4, 32'd1});
    end
    handshake();
  endtask

  task automatic test_reset_mid_parse();
    parser_en = 1'b0;
    send_bytes(10, 8'h60, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_pkt_len !== 16'd10) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got valid=%b rdy=%b len=%0d expected 0 0 10",
               out_valid, in_ready, out_pkt_len);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || start !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0 ||
        pkt_hdr !== '0 || out_hdrs !== '0 || out_pkt_len !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrst_async: got rdy=%b valid=%b hdrs=%h len=%0d win0=%h expected all 0",
               in_ready, out_valid, out_hdrs, out_pkt_len, pkt_hdr[31:0]);
    end
    #3;
    rst = 1'b1;
    parser_en = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_release: got rdy=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

`ifdef HDR_COLLECTOR_TIMEOUT_EN
  task automatic test_timeout();
    int cycles;
    parser_en = 1'b0;
    send_bytes(8, 8'h70, 1'b1, 1'b1);
    tick();
    checks++;
    if (start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_start: got %b expected 1", start);
    end
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cycles++;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (cycles !== TIMEOUT + 1) begin
      errors++;
      $display("[TB] FAIL to_latency: got %0d cycles expected %0d", cycles, TIMEOUT + 1);
    end
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_hdrs !== {NUM_HDRS{`NO_HEADER}} ||
        out_pkt_len !== 16'd8) begin
      errors++;
      $display("[TB] FAIL to_result: got valid=%b err=%b hdrs=%h len=%0d expected 1 1 %h 8",
               out_valid, out_err, out_hdrs, out_pkt_len, {NUM_HDRS{`NO_HEADER}});
    end
    handshake();
    checks++;
    if (out_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_clear: got err=%b valid=%b expected 0 0", out_err, out_valid);
    end
    parser_en = 1'b1;
  endtask
`endif

  initial begin
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_sop     = 1'b0;
    in_eop     = 1'b0;
    mod_busy   = 1'b0;
    out_ready  = 1'b0;
    model_hdrs = '0;
    test_reset();
    test_short_packet();
    test_long_packet();
    test_mod_busy();
    test_back_to_back();
    test_stray_restart();
    test_reset_mid_parse();
`ifdef HDR_COLLECTOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
